// File: rtl/midori_mask_pkg.sv
// midori_mask_pkg: share/width constants and compression indexing for the masked Midori S-box
package midori_mask_pkg;
   localparam int NSHARES    = 3;
   localparam int NCF        = 27;
   localparam int G_OUT_BITS = 3;
   // Component bit k of share j of output bit i
   function automatic int cf_idx(input int i, input int j, input int k);
      return NSHARES * (NSHARES * i + j) + k;
   endfunction
endpackage

// File: rtl/share_xor3.sv
// share_xor3: 3-input XOR folding three component bits into one output share
module share_xor3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = a ^ b ^ c;
endmodule

// File: rtl/midori_g_compress.sv
// midori_g_compress: glitch-barrier register and XOR compression of the 27 masked G component bits
module midori_g_compress
   import midori_mask_pkg::*;
#(
   parameter bit PIPE_OUT = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [NCF-1:0]                  cf_q,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            rand_valid,
   output logic                            rand_ack,
   output logic [NSHARES*G_OUT_BITS-1:0]   out_sh,
   output logic                            out_valid,
   input  logic                            out_ready
);
   logic [NCF-1:0]                s1_q;
   logic                          s1_v;
   logic [NSHARES*G_OUT_BITS-1:0] c;
   logic                          acc;
   logic                          s1_drain;
   logic                          ready_raw;

   // Reset and flush both block acceptance so no fresh randomness is consumed
   assign in_ready = !rst && !flush && ready_raw;
   assign acc      = in_valid && rand_valid && in_ready;
   assign rand_ack = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s1_v <= 1'b0;
      end else if (flush) begin
         s1_q <= '0;
         s1_v <= 1'b0;
      end else begin
         if (acc) s1_q <= cf_q;
         s1_v <= acc || (s1_v && !s1_drain);
      end
   end

   for (genvar i = 0; i < G_OUT_BITS; i++) begin : g_bit
      for (genvar j = 0; j < NSHARES; j++) begin : g_sh
         share_xor3 u_xor (
            .a(s1_q[cf_idx(i, j, 0)]),
            .b(s1_q[cf_idx(i, j, 1)]),
            .c(s1_q[cf_idx(i, j, 2)]),
            .y(c[NSHARES * i + j])
         );
      end
   end

   if (PIPE_OUT) begin : g_s2
      logic [NSHARES*G_OUT_BITS-1:0] s2_sh;
      logic                          s2_v;
      logic                          s2_load;
      assign s2_load   = s1_v && (!s2_v || out_ready);
      assign s1_drain  = s2_load;
      assign ready_raw = !s1_v || s2_load;
      assign out_sh    = s2_sh;
      assign out_valid = s2_v;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s2_sh <= '0;
            s2_v  <= 1'b0;
         end else if (flush) begin
            s2_sh <= '0;
            s2_v  <= 1'b0;
         end else begin
            if (s2_load) s2_sh <= c;
            s2_v <= s2_load || (s2_v && !out_ready);
         end
      end
   end else begin : g_comb
      assign s1_drain  = s1_v && out_ready;
      assign ready_raw = !s1_v || out_ready;
      assign out_sh    = c;
      assign out_valid = s1_v;
   end
endmodule

// File: tb/tb_midori_g_compress.sv
// tb_midori_g_compress: directed checks of both pipeline variants of midori_g_compress
module tb_midori_g_compress;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [26:0] cf_q = 27'h0000007;
   logic        in_valid = 1'b1;
   logic        rand_valid = 1'b1;
   logic        out_ready = 1'b1;
   logic        in_ready, rand_ack, out_valid;
   logic [8:0]  out_sh;
   logic [26:0] b_cf_q = '0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready, b_rand_ack, b_out_valid;
   logic [8:0]  b_out_sh;
   int          n_chk = 0;
   int          n_pass = 0;
   int          ack_cnt = 0;
   int          out_cnt = 0;

   always #5 clk = ~clk;

   midori_g_compress #(.PIPE_OUT(1'b1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .cf_q(cf_q), .in_valid(in_valid),
      .in_ready(in_ready), .rand_valid(rand_valid), .rand_ack(rand_ack),
      .out_sh(out_sh), .out_valid(out_valid), .out_ready(out_ready)
   );

   midori_g_compress #(.PIPE_OUT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .cf_q(b_cf_q), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .rand_valid(1'b1), .rand_ack(b_rand_ack),
      .out_sh(b_out_sh), .out_valid(b_out_valid), .out_ready(1'b1)
   );

   always @(posedge clk) begin
      if (!rst && rand_ack) ack_cnt++;
      if (!rst && out_valid && out_ready) out_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic send_check(input string tag, input logic [26:0] cf, input logic [8:0] exp);
      @(negedge clk);
      in_valid = 1'b1;
      cf_q = cf;
      #1 chk({tag, "_ack"}, rand_ack, 1);
      edge1();
      in_valid = 1'b0;
      chk({tag, "_ov_n"}, out_valid, 0);
      edge1();
      chk({tag, "_ov_n1"}, out_valid, 1);
      chk({tag, "_sh"}, out_sh, exp);
   endtask

   initial begin
      edge1();
      edge1();
      chk("rst_sh", out_sh, 9'h000);
      chk("rst_ov", out_valid, 0);
      chk("rst_ack", rand_ack, 0);
      chk("rst_ack0", b_rand_ack, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1 chk("rst_rdy", in_ready, 1);
      chk("rst_rdy0", b_in_ready, 1);

      send_check("c7", 27'h0000007, 9'h001);
      send_check("c3", 27'h0000003, 9'h000);
      send_check("cff", 27'h7FFFFFF, 9'h1FF);
      send_check("c1c", 27'h01C0E07, 9'h049);
      edge1();
      chk("idle_ov", out_valid, 0);

      // backpressure: A, B buffered, C held
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      cf_q = 27'h0000007;
      #1 chk("bp_ackA", rand_ack, 1);
      edge1();
      cf_q = 27'h0000038;
      chk("bp_ackB", rand_ack, 1);
      edge1();
      cf_q = 27'h01C0E07;
      chk("bp_rdyC", in_ready, 0);
      chk("bp_ackC", rand_ack, 0);
      for (int k = 0; k < 2; k++) begin
         edge1();
         chk("bp_hold_ack", rand_ack, 0);
         chk("bp_hold_ov", out_valid, 1);
         chk("bp_hold_sh", out_sh, 9'h001);
      end
      out_ready = 1'b1;
      #1 chk("bp_ackC2", rand_ack, 1);
      chk("bp_outA", out_sh, 9'h001);
      edge1();
      in_valid = 1'b0;
      chk("bp_ovB", out_valid, 1);
      chk("bp_outB", out_sh, 9'h002);
      edge1();
      chk("bp_ovC", out_valid, 1);
      chk("bp_outC", out_sh, 9'h049);
      edge1();
      chk("bp_done", out_valid, 0);

      // randomness gating
      @(negedge clk);
      ack_cnt = 0;
      out_cnt = 0;
      in_valid = 1'b1;
      cf_q = 27'h0000007;
      rand_valid = 1'b1;
      @(negedge clk);
      rand_valid = 1'b0;
      #1 chk("rg_ack0", rand_ack, 0);
      @(negedge clk);
      rand_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) edge1();
      chk("rg_acks", ack_cnt, 2);
      chk("rg_outs", out_cnt, 2);

      // flush with S1 and S2 full
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      cf_q = 27'h0000007;
      edge1();
      cf_q = 27'h0000038;
      edge1();
      chk("fl_full", out_valid, 1);
      @(negedge clk);
      flush = 1'b1;
      cf_q = 27'h7FFFFFF;
      #1 chk("fl_rdy", in_ready, 0);
      chk("fl_ack", rand_ack, 0);
      edge1();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_ov", out_valid, 0);
      chk("fl_sh", out_sh, 9'h000);
      chk("fl_s1q", u_dut.s1_q, 0);
      chk("fl_s1v", u_dut.s1_v, 0);
      out_ready = 1'b1;
      edge1();
      edge1();
      chk("fl_after", out_valid, 0);

      // single-stage variant
      @(negedge clk);
      b_in_valid = 1'b1;
      b_cf_q = 27'h0000038;
      #1 chk("p0_ack", b_rand_ack, 1);
      chk("p0_ov_pre", b_out_valid, 0);
      edge1();
      b_in_valid = 1'b0;
      chk("p0_ov", b_out_valid, 1);
      chk("p0_sh", b_out_sh, 9'h002);
      edge1();
      chk("p0_drain", b_out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
